// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and enums for the write-back port arbiter
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Source of the register-file write this cycle
  typedef enum logic {
    RF_SRC_PIPE = 1'b0,
    RF_SRC_LU   = 1'b1
  } rf_src_e;

  // Write-port grant, listed in decreasing priority after NONE
  typedef enum logic [2:0] {
    GNT_NONE  = 3'd0,
    GNT_FORCE = 3'd1,
    GNT_PIPE  = 3'd2,
    GNT_DRAIN = 3'd3,
    GNT_BYP   = 3'd4
  } gnt_e;

endpackage

// File: rtl/wb_port_arbiter_pend_fifo.sv
// rtl/wb_port_arbiter_pend_fifo.sv - LU result FIFO with parallel pending-rd compare
//   clk, rst_n                      : clock, async active-low reset
//   push, push_rd, push_data        : enqueue one result (caller guarantees !full)
//   pop                             : dequeue head (caller guarantees !empty)
//   head_rd, head_data              : current head entry
//   count, full, empty              : occupancy
//   chk_rs1, chk_rs2, chk_rd        : decode addresses compared against pending entries
//   chk_hit                         : any non-zero chk address matches a valid entry
module wb_pend_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [DW-1:0]     push_data,
  input  logic              pop,
  output logic [REG_AW-1:0] head_rd,
  output logic [DW-1:0]     head_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              chk_hit
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [REG_AW-1:0] r_rd_mem   [DEPTH];
  logic [DW-1:0]     r_data_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only slots covered by r_count are ever observed
  always_ff @(posedge clk) begin
    if (push) begin
      r_rd_mem[r_wr_ptr]   <= push_rd;
      r_data_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head_rd   = r_rd_mem[r_rd_ptr];
  assign head_data = r_data_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);

  // A slot is pending when its distance from the read pointer is below the
  // occupancy; the head being popped this cycle still counts.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(AW'(AW'(i) - r_rd_ptr)) < r_count) && (r_rd_mem[i] != '0)) begin
        if (((chk_rs1 != '0) && (chk_rs1 == r_rd_mem[i])) ||
            ((chk_rs2 != '0) && (chk_rs2 == r_rd_mem[i])) ||
            ((chk_rd  != '0) && (chk_rd  == r_rd_mem[i])))
          chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port shared by pipeline WB and long-latency unit
//   wb_valid/wb_rd/wb_wdata    : pipeline write-back request (priority source)
//   lu_valid/lu_rd/lu_data     : LU result, accepted when lu_ready
//   chk_rs1/chk_rs2/chk_rd     : decode hazard query, answered on chk_hit
//   rf_we/rf_waddr/rf_wdata    : register-file write port, rf_src tags the source
//   pipe_stall                 : one-cycle forced drain holding WB and earlier stages
//   pend_cnt                   : buffered LU results
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              chk_hit,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              rf_src,
  output logic              pipe_stall,
  output logic [CW-1:0]     pend_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]     r_starve;
  gnt_e              w_gnt;
  logic              w_pipe_wr;
  logic              w_lu_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic [CW-1:0]     w_count;
  logic [REG_AW-1:0] w_head_rd;
  logic [XLEN-1:0]   w_head_data;

  assign w_pipe_wr = wb_valid && (wb_rd != '0);
  // Depends only on state (full), never on this cycle's pop
  assign w_lu_acc  = lu_valid && !w_full && (lu_rd != '0);

  always_comb begin
    w_gnt = GNT_NONE;
    if (!w_empty && (r_starve == SW'(STARVE_LIMIT)) && w_pipe_wr) w_gnt = GNT_FORCE;
    else if (w_pipe_wr)                                           w_gnt = GNT_PIPE;
    else if (!w_empty)                                            w_gnt = GNT_DRAIN;
    else if (w_lu_acc)                                            w_gnt = GNT_BYP;
  end

  // A bypassed result goes straight to the register file and is never queued
  assign w_push = w_lu_acc && (w_gnt != GNT_BYP);
  assign w_pop  = (w_gnt == GNT_FORCE) || (w_gnt == GNT_DRAIN);

  wb_pend_fifo #(
    .DEPTH (DEPTH),
    .DW    (XLEN),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .pop       (w_pop),
    .head_rd   (w_head_rd),
    .head_data (w_head_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .chk_hit   (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if ((w_gnt == GNT_PIPE) && (r_starve != SW'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Outputs are gated by rst_n so nothing leaks from live inputs during reset
  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    rf_src     = RF_SRC_PIPE;
    pipe_stall = 1'b0;
    if (rst_n) begin
      case (w_gnt)
        GNT_FORCE: begin
          rf_we      = 1'b1;
          rf_waddr   = w_head_rd;
          rf_wdata   = w_head_data;
          rf_src     = RF_SRC_LU;
          pipe_stall = 1'b1;
        end
        GNT_PIPE: begin
          rf_we    = 1'b1;
          rf_waddr = wb_rd;
          rf_wdata = wb_wdata;
          rf_src   = RF_SRC_PIPE;
        end
        GNT_DRAIN: begin
          rf_we    = 1'b1;
          rf_waddr = w_head_rd;
          rf_wdata = w_head_data;
          rf_src   = RF_SRC_LU;
        end
        GNT_BYP: begin
          rf_we    = 1'b1;
          rf_waddr = lu_rd;
          rf_wdata = lu_data;
          rf_src   = RF_SRC_LU;
        end
        default: ;
      endcase
    end
  end

  assign lu_ready = rst_n && !w_full;
  assign chk_hit  = rst_n && w_hit;
  assign pend_cnt = rst_n ? w_count : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        chk_hit;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic        pipe_stall;
  logic [2:0]  pend_cnt;

  int n_cmp;
  int n_fail;

  wb_port_arbiter #(
    .XLEN         (32),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_wdata   (wb_wdata),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .chk_hit    (chk_hit),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_src     (rf_src),
    .pipe_stall (pipe_stall),
    .pend_cnt   (pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rd, input logic [31:0] d,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    wb_valid = v;
    wb_rd    = rd;
    wb_wdata = d;
    lu_valid = lv;
    lu_rd    = lrd;
    lu_data  = ld;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    chk_rs1 = 5'd0;
    chk_rs2 = 5'd0;
    chk_rd  = 5'd0;
    drv(1'b1, 5'd3, 32'h1111, 1'b1, 5'd5, 32'h2222);
    #3;
    check("rst_rf_we",      rf_we,      0);
    check("rst_lu_ready",   lu_ready,   0);
    check("rst_pipe_stall", pipe_stall, 0);
    check("rst_pend_cnt",   pend_cnt,   0);
    check("rst_rf_waddr",   rf_waddr,   0);
    tick;
    rst_n = 1'b1;

    // Idle pipeline: LU result bypasses straight to the register file
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    mid;
    check("byp_rf_we",    rf_we,    1);
    check("byp_waddr",    rf_waddr, 5);
    check("byp_wdata",    rf_wdata, 32'hDEAD_BEEF);
    check("byp_src",      rf_src,   1);
    check("byp_lu_ready", lu_ready, 1);
    check("byp_stall",    pipe_stall, 0);
    tick;

    // Destination 0 on both sides: no write, no enqueue
    drv(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h55);
    mid;
    check("byp_pend_cnt", pend_cnt, 0);
    check("z_rf_we",      rf_we,    0);
    check("z_lu_ready",   lu_ready, 1);
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    mid;
    check("z_pend_cnt", pend_cnt, 0);
    tick;

    // Pipeline busy: four LU results fill the FIFO
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 5'd1, 32'h100, 1'b1, 5'(10 + k), 32'(32'hA0 + k));
      mid;
      check("fill_lu_ready", lu_ready, 1);
      check("fill_waddr",    rf_waddr, 1);
      check("fill_src",      rf_src,   0);
      check("fill_pend",     pend_cnt, 3'(k));
      tick;
    end

    // Fifth result refused while full; scoreboard sees every pending rd
    drv(1'b1, 5'd1, 32'h100, 1'b1, 5'd14, 32'hA4);
    mid;
    check("full_lu_ready", lu_ready, 0);
    check("full_pend",     pend_cnt, 4);
    check("full_waddr",    rf_waddr, 1);
    check("full_stall",    pipe_stall, 0);
    chk_rs1 = 5'd10;
    #1 check("hit_rs1_10", chk_hit, 1);
    chk_rs1 = 5'd0; chk_rs2 = 5'd13;
    #1 check("hit_rs2_13", chk_hit, 1);
    chk_rs2 = 5'd0; chk_rd = 5'd11;
    #1 check("hit_rd_11", chk_hit, 1);
    chk_rd = 5'd14;
    #1 check("hit_rd_14", chk_hit, 0);
    chk_rd = 5'd0;
    tick;

    // Pipeline idle: drain pops while push is still refused this cycle
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hA4);
    mid;
    check("drf_lu_ready", lu_ready, 0);
    check("drf_rf_we",    rf_we,    1);
    check("drf_waddr",    rf_waddr, 10);
    check("drf_wdata",    rf_wdata, 32'hA0);
    check("drf_src",      rf_src,   1);
    check("drf_pend",     pend_cnt, 4);
    tick;
    mid;
    check("dr1_lu_ready", lu_ready, 1);
    check("dr1_waddr",    rf_waddr, 11);
    check("dr1_wdata",    rf_wdata, 32'hA1);
    check("dr1_pend",     pend_cnt, 3);
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int j = 0; j < 3; j++) begin
      mid;
      check("drn_waddr", rf_waddr, 5'(12 + j));
      check("drn_wdata", rf_wdata, 32'(32'hA2 + j));
      check("drn_pend",  pend_cnt, 3'(3 - j));
      tick;
    end
    mid;
    check("drn_empty_we",   rf_we,    0);
    check("drn_empty_pend", pend_cnt, 0);
    tick;

    // Starvation: one buffered entry under continuous pipeline writes
    drv(1'b1, 5'd2, 32'h200, 1'b1, 5'd7, 32'h77);
    mid;
    check("stv_push_waddr", rf_waddr, 2);
    check("stv_push_src",   rf_src,   0);
    tick;
    drv(1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      mid;
      check("stv_pipe_stall", pipe_stall, 0);
      check("stv_pipe_waddr", rf_waddr,   2);
      check("stv_pipe_pend",  pend_cnt,   1);
      tick;
    end
    mid;
    check("stv_force_stall", pipe_stall, 1);
    check("stv_force_we",    rf_we,      1);
    check("stv_force_waddr", rf_waddr,   7);
    check("stv_force_wdata", rf_wdata,   32'h77);
    check("stv_force_src",   rf_src,     1);
    tick;
    mid;
    check("stv_after_stall", pipe_stall, 0);
    check("stv_after_waddr", rf_waddr,   2);
    check("stv_after_wdata", rf_wdata,   32'h200);
    check("stv_after_src",   rf_src,     0);
    check("stv_after_pend",  pend_cnt,   0);
    tick;

    // Asynchronous reset with three entries pending
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 5'd4, 32'h400, 1'b1, 5'(20 + k), 32'(32'hC0 + k));
      tick;
    end
    drv(1'b1, 5'd4, 32'h400, 1'b1, 5'd23, 32'hC3);
    chk_rs1 = 5'd20;
    mid;
    check("pre_rst_pend", pend_cnt, 3);
    check("pre_rst_hit",  chk_hit,  1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_we",       rf_we,      0);
    check("mid_rst_waddr",    rf_waddr,   0);
    check("mid_rst_wdata",    rf_wdata,   0);
    check("mid_rst_lu_ready", lu_ready,   0);
    check("mid_rst_stall",    pipe_stall, 0);
    check("mid_rst_hit",      chk_hit,    0);
    check("mid_rst_pend",     pend_cnt,   0);
    tick;
    rst_n = 1'b1;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    mid;
    check("post_rst_pend",     pend_cnt, 0);
    check("post_rst_hit",      chk_hit,  0);
    check("post_rst_we",       rf_we,    0);
    check("post_rst_lu_ready", lu_ready, 1);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
